// File: rtl/alu_8b_pkg.sv
// Shared definitions for the 8-bit ALU: operand/result widths and opcode encoding.
package alu_8b_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  // 3-bit operation select
  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_L_SHIFT = 3'b011,
    OP_R_SHIFT = 3'b100,
    OP_AND     = 3'b101,
    OP_OR      = 3'b110,
    OP_XOR     = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_8b_comb.sv
// Combinational ALU datapath: unsigned operands, 16-bit result plus carry/borrow.
module alu_8b_comb
  import alu_8b_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [RES_W-1:0]  result,
  output logic              carry
);

  alu_op_e           op;
  logic [RES_W-1:0]  a_wide;
  logic [RES_W-1:0]  b_wide;
  logic [DATA_W:0]   sum9;
  logic [DATA_W:0]   diff9;

  assign op     = alu_op_e'(opcode);
  assign a_wide = {{(RES_W-DATA_W){1'b0}}, a};
  assign b_wide = {{(RES_W-DATA_W){1'b0}}, b};
  // 9-bit add/sub; the top bit is the carry out or the borrow (set iff a < b)
  assign sum9   = {1'b0, a} + {1'b0, b};
  assign diff9  = {1'b0, a} - {1'b0, b};

  // Operation select; only add/sub drive the carry flag
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = {{(RES_W-DATA_W-1){1'b0}}, sum9};
        carry  = sum9[DATA_W];
      end
      OP_SUB: begin
        result = {{(RES_W-DATA_W-1){1'b0}}, diff9};
        carry  = diff9[DATA_W];
      end
      OP_MUL:     result = a_wide * b_wide;
      // Shift amounts at or beyond the field width are forced to zero explicitly
      OP_L_SHIFT: result = (b >= DATA_W'(RES_W))  ? '0 : (a_wide << b[3:0]);
      OP_R_SHIFT: result = (b >= DATA_W'(DATA_W)) ? '0 : (a_wide >> b[2:0]);
      OP_AND:     result = {{(RES_W-DATA_W){1'b0}}, a & b};
      OP_OR:      result = {{(RES_W-DATA_W){1'b0}}, a | b};
      OP_XOR:     result = {{(RES_W-DATA_W){1'b0}}, a ^ b};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8b.sv
// 8-bit ALU top: combinational datapath followed by one registered output stage.
module alu_8b
  import alu_8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [RES_W-1:0]  outALU,
  output logic              cout,
  output logic              out_valid
);

  logic [RES_W-1:0] res_comb;
  logic             carry_comb;
  logic [RES_W-1:0] res_p0;
  logic             cout_p0;
  logic             vld_p0;

  alu_8b_comb u_comb (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .result (res_comb),
    .carry  (carry_comb)
  );

  // ---- stage p0: output register; results hold while no new operation arrives ----
  // Reset clears the visible result too, and wins over a same-cycle operation
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p0  <= '0;
      cout_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        res_p0  <= res_comb;
        cout_p0 <= carry_comb;
      end
    end
  end

  assign outALU    = res_p0;
  assign cout      = cout_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_alu_8b.sv
// Self-checking bench for alu_8b: directed vectors plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_8b;
  import alu_8b_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  opcode;
  logic [15:0] outALU;
  logic        cout;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] last_res;
  logic        last_cout;

  alu_8b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .outALU    (outALU),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {cout, result} from plain integer arithmetic
  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] ta, input logic [7:0] tb_v);
    int ia, ib, r;
    logic c;
    ia = int'(ta);
    ib = int'(tb_v);
    c  = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin r = (ia - ib + 512) % 512; c = (ia < ib); end
      3'd2: r = ia * ib;
      3'd3: r = (ib >= 16) ? 0 : ((ia * (1 << ib)) % 65536);
      3'd4: r = (ib >= 8) ? 0 : (ia / (1 << ib));
      3'd5: r = int'(ta & tb_v);
      3'd6: r = int'(ta | tb_v);
      default: r = int'(ta ^ tb_v);
    endcase
    return {c, 16'(r)};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] ta, input logic [7:0] tb_v);
    logic [16:0] e;
    e        = model(op, ta, tb_v);
    in_valid = 1'b1;
    opcode   = op;
    a        = ta;
    b        = tb_v;
    @(posedge clk);
    #1;
    check({tag, ".res"}, 32'(outALU), 32'(e[15:0]));
    check({tag, ".cout"}, 32'(cout), 32'(e[16]));
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    last_res  = e[15:0];
    last_cout = e[16];
  endtask

  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    opcode   = 3'($urandom);
    a        = 8'($urandom);
    b        = 8'($urandom);
    @(posedge clk);
    #1;
    check({tag, ".hold_res"}, 32'(outALU), 32'(last_res));
    check({tag, ".hold_cout"}, 32'(cout), 32'(last_cout));
    check({tag, ".vld0"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [7:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
    last_res = '0; last_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.res", 32'(outALU), 32'h0);
    check("reset.cout", 32'(cout), 32'h0);
    check("reset.vld", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // First rst=0 edge without an operation must not produce a result
    idle_cycle("post_reset_idle");

    do_op("add_f0_30", OP_ADD, 8'hF0, 8'h30);
    check("add_f0_30.abs", 32'(outALU), 32'h0120);
    do_op("sub_50_10", OP_SUB, 8'h50, 8'h10);
    do_op("sub_10_50", OP_SUB, 8'h10, 8'h50);
    check("sub_10_50.abs", 32'(outALU), 32'h01C0);
    do_op("mul_10_04", OP_MUL, 8'h10, 8'h04);
    do_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF);
    check("mul_ff_ff.abs", 32'(outALU), 32'hFE01);
    do_op("lsh_01_03", OP_L_SHIFT, 8'h01, 8'h03);
    do_op("lsh_ff_08", OP_L_SHIFT, 8'hFF, 8'h08);
    check("lsh_ff_08.abs", 32'(outALU), 32'hFF00);
    do_op("lsh_ff_0f", OP_L_SHIFT, 8'hFF, 8'h0F);
    do_op("lsh_ff_10", OP_L_SHIFT, 8'hFF, 8'h10);
    do_op("rsh_80_03", OP_R_SHIFT, 8'h80, 8'h03);
    do_op("rsh_80_07", OP_R_SHIFT, 8'h80, 8'h07);
    do_op("rsh_80_09", OP_R_SHIFT, 8'h80, 8'h09);
    do_op("and_aa_0f", OP_AND, 8'hAA, 8'h0F);
    check("and_aa_0f.abs", 32'(outALU), 32'h000A);
    do_op("or_a0_0f", OP_OR, 8'hA0, 8'h0F);
    do_op("xor_ff_0f", OP_XOR, 8'hFF, 8'h0F);
    check("xor_ff_0f.abs", 32'(outALU), 32'h00F0);

    // Back-to-back add then XOR, then hold
    do_op("b2b_add", OP_ADD, 8'hFF, 8'h01);
    do_op("b2b_xor", OP_XOR, 8'h5A, 8'hA5);
    idle_cycle("hold1");
    idle_cycle("hold2");

    // Reset wins over a concurrent operation
    do_op("pre_rst", OP_MUL, 8'h12, 8'h34);
    rst = 1'b1; in_valid = 1'b1; opcode = OP_MUL; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1;
    check("rst_pri.res", 32'(outALU), 32'h0);
    check("rst_pri.cout", 32'(cout), 32'h0);
    check("rst_pri.vld", 32'(out_valid), 32'h0);
    rst = 1'b0;
    last_res = '0; last_cout = 1'b0;
    idle_cycle("rst_idle");
    do_op("first_after_rst", OP_SUB, 8'h00, 8'h01);

    // Randomized operations with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
      if ($urandom_range(0, 7) == 0) idle_cycle($sformatf("rnd%0d_idle", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
